// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite slave register file that configures the DMA engine, issues start and tracks completions.
// Optional: define DMAC_REGS_ERR_EN for two-cycle ERROR responses to out-of-range or non-word accesses.

module dmac_ahbl_regs #(
    parameter int CNT_W = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [31:0] icra,
    output logic [31:0] icrv,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic [2:0]  irqsrc,
    output logic [7:0]  bsize,
    output logic [7:0]  bcount,
    output logic        wfi,
    output logic        start,
    input  logic        done,
    input  logic        busy,
    output logic        irq
);

    localparam logic [5:0] IX_SADDR   = 6'd0;
    localparam logic [5:0] IX_DADDR   = 6'd1;
    localparam logic [5:0] IX_CFG     = 6'd2;
    localparam logic [5:0] IX_GEOM    = 6'd3;
    localparam logic [5:0] IX_CTRL    = 6'd4;
    localparam logic [5:0] IX_STATUS  = 6'd5;
    localparam logic [5:0] IX_IE      = 6'd6;
    localparam logic [5:0] IX_ICRA    = 6'd7;
    localparam logic [5:0] IX_ICRV    = 6'd8;
    localparam logic [5:0] IX_DONECNT = 6'd9;

    typedef enum logic [1:0] {RSP_OKAY, RSP_ERR1, RSP_ERR2} rsp_t;

    logic             acc;
    logic             err_acc;
    logic             wr_en;
    logic             wr_p1;
    logic             rd_p1;
    logic [5:0]       idx_p1;
    rsp_t             rsp_st;
    logic             hreadyout_r;
    logic             hresp_r;
    logic [31:0]      saddr_r, daddr_r, icra_r, icrv_r;
    logic [2:0]       ssize_r, dsize_r, sinc_r, dinc_r, irqsrc_r;
    logic [7:0]       bsize_r, bcount_r;
    logic             wfi_r;
    logic             start_r;
    logic             ie_r, done_r, irq_r;
    logic             ie_nx, done_nx;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      cnt_ext;
    logic [31:0]      rdata;

    assign acc = HSEL & HTRANS[1] & HREADY;

`ifdef DMAC_REGS_ERR_EN
    assign err_acc = (HADDR[7:2] > IX_DONECNT) || (HSIZE != 3'b010);
    logic unused_in;
    assign unused_in = ^{HADDR[31:8], HADDR[1:0], HTRANS[0]};
`else
    assign err_acc = 1'b0;
    logic unused_in;
    assign unused_in = ^{HADDR[31:8], HADDR[1:0], HTRANS[0], HSIZE};
`endif

    // ---- address phase -> data phase flags ----
    // Flags hold while HREADY is low so a stalled data phase keeps its decode.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_p1  <= 1'b0;
            rd_p1  <= 1'b0;
            idx_p1 <= '0;
        end else if (HREADY) begin
            wr_p1  <= acc & HWRITE & ~err_acc;
            rd_p1  <= acc & ~HWRITE & ~err_acc;
            idx_p1 <= acc ? HADDR[7:2] : 6'd0;
        end
    end

    // Response FSM: OKAY normally, ERROR as one wait cycle then one ready cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_st      <= RSP_OKAY;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            case (rsp_st)
                RSP_ERR1: begin
                    rsp_st      <= RSP_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= 1'b1;
                end
                default: begin
                    if (acc && err_acc) begin
                        rsp_st      <= RSP_ERR1;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= 1'b1;
                    end else begin
                        rsp_st      <= RSP_OKAY;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wr_en = wr_p1 & HREADY;

    // A done pulse outranks a same-cycle W1C of DONE.
    assign done_nx = done | (done_r & ~(wr_en && (idx_p1 == IX_STATUS) && HWDATA[1]));
    assign ie_nx   = (wr_en && (idx_p1 == IX_IE)) ? HWDATA[0] : ie_r;

    // ---- data phase -> register update ----
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            saddr_r  <= '0;
            daddr_r  <= '0;
            icra_r   <= '0;
            icrv_r   <= '0;
            ssize_r  <= '0;
            dsize_r  <= '0;
            sinc_r   <= '0;
            dinc_r   <= '0;
            irqsrc_r <= '0;
            wfi_r    <= 1'b0;
            bsize_r  <= '0;
            bcount_r <= '0;
            start_r  <= 1'b0;
            ie_r     <= 1'b0;
            done_r   <= 1'b0;
            irq_r    <= 1'b0;
            cnt_r    <= '0;
        end else begin
            if (wr_en && !busy) begin
                case (idx_p1)
                    IX_SADDR: saddr_r <= HWDATA;
                    IX_DADDR: daddr_r <= HWDATA;
                    IX_CFG: begin
                        ssize_r  <= HWDATA[2:0];
                        dsize_r  <= HWDATA[6:4];
                        sinc_r   <= HWDATA[10:8];
                        dinc_r   <= HWDATA[14:12];
                        irqsrc_r <= HWDATA[18:16];
                        wfi_r    <= HWDATA[20];
                    end
                    IX_GEOM: begin
                        bsize_r  <= HWDATA[7:0];
                        bcount_r <= HWDATA[15:8];
                    end
                    IX_ICRA: icra_r <= HWDATA;
                    IX_ICRV: icrv_r <= HWDATA;
                    default: ;
                endcase
            end
            start_r <= wr_en && (idx_p1 == IX_CTRL) && HWDATA[0] && !busy;
            ie_r    <= ie_nx;
            done_r  <= done_nx;
            irq_r   <= done_nx & ie_nx;
            if (wr_en && (idx_p1 == IX_DONECNT))
                cnt_r <= done ? CNT_W'(1) : '0;
            else if (done)
                cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = cnt_r;
    end

    always_comb begin
        rdata = '0;
        if (rd_p1) begin
            case (idx_p1)
                IX_SADDR:   rdata = saddr_r;
                IX_DADDR:   rdata = daddr_r;
                IX_CFG:     rdata = {11'b0, wfi_r, 1'b0, irqsrc_r, 1'b0, dinc_r,
                                     1'b0, sinc_r, 1'b0, dsize_r, 1'b0, ssize_r};
                IX_GEOM:    rdata = {16'b0, bcount_r, bsize_r};
                IX_STATUS:  rdata = {30'b0, done_r, busy};
                IX_IE:      rdata = {31'b0, ie_r};
                IX_ICRA:    rdata = icra_r;
                IX_ICRV:    rdata = icrv_r;
                IX_DONECNT: rdata = cnt_ext;
                default:    rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;
    assign saddr     = saddr_r;
    assign daddr     = daddr_r;
    assign icra      = icra_r;
    assign icrv      = icrv_r;
    assign ssize     = ssize_r;
    assign dsize     = dsize_r;
    assign sinc      = sinc_r;
    assign dinc      = dinc_r;
    assign irqsrc    = irqsrc_r;
    assign wfi       = wfi_r;
    assign bsize     = bsize_r;
    assign bcount    = bcount_r;
    assign start     = start_r;
    assign irq       = irq_r;

endmodule
